// File: rtl/inst_decode_queue_if.sv
// Fetch/execute handshake bundle for the decode queue.
// The slave modport is the queue's view; the master modport is the surrounding pipeline's view.
interface inst_decode_queue_if #(
  parameter int unsigned INST_MEM_WIDTH = 2,
  parameter int unsigned DEPTH          = 2
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // fetch side
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               inst;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic                      distinct;

  // execute side
  logic                      out_valid;
  logic                      out_ready;
  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [4:0]                rs;
  logic [4:0]                rt;
  logic [4:0]                rd;
  logic [4:0]                sa;
  logic [15:0]               immediate;
  logic [31:0]               imm_sext;
  logic [25:0]               inst_index;
  logic [INST_MEM_WIDTH-1:0] pc_next;
  logic [INST_MEM_WIDTH-1:0] pc1_next;
  logic                      distinct_next;
  logic [OCC_W-1:0]          occupancy;

  modport slave (
    input  in_valid, inst, pc, pc1, distinct, out_ready,
    output in_ready, out_valid, opcode, funct, rs, rt, rd, sa, immediate,
           imm_sext, inst_index, pc_next, pc1_next, distinct_next, occupancy
  );

  modport master (
    output in_valid, inst, pc, pc1, distinct, out_ready,
    input  in_ready, out_valid, opcode, funct, rs, rt, rd, sa, immediate,
           imm_sext, inst_index, pc_next, pc1_next, distinct_next, occupancy
  );
endinterface

// File: rtl/inst_decode_queue.sv
// Decode-stage instruction FIFO: buffers fetched instructions, holds each head entry a
// configurable number of cycles, then presents the split fields to execute via valid/ready.
module inst_decode_queue #(
  parameter int unsigned INST_MEM_WIDTH = 2,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned WAIT_CYCLES    = 2
) (
  input logic              CLK,
  input logic              reset,
  input logic              flush,
  inst_decode_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = 4;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_CYCLES);

  logic [31:0]               inst_mem [DEPTH];
  logic [INST_MEM_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_MEM_WIDTH-1:0] pc1_mem  [DEPTH];
  logic                      dist_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [OCC_W-1:0] occ, occ_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

  logic in_ready_w;
  logic out_valid_w;
  logic push;
  logic pop;

  // Handshake: no pass-through when full, flush blocks both push and pop.
  always_comb begin
    in_ready_w  = (occ < OCC_FULL) & ~flush;
    out_valid_w = (occ != '0) & (wait_cnt == WAIT_MAX);
    push        = bus.in_valid & in_ready_w;
    pop         = out_valid_w & bus.out_ready & ~flush;
  end

  // Next-state for pointers, occupancy and head wait counter.
  always_comb begin
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    occ_n      = occ;
    wait_cnt_n = wait_cnt;
    if (flush) begin
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      occ_n      = '0;
      wait_cnt_n = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occ_n = occ + OCC_W'(1);
        2'b01:   occ_n = occ - OCC_W'(1);
        default: occ_n = occ;
      endcase
      // A pop always either exposes a new head or empties the queue; both restart the wait.
      if (pop || (push && (occ == '0))) begin
        wait_cnt_n = '0;
      end else if ((occ != '0) && (wait_cnt != WAIT_MAX)) begin
        wait_cnt_n = wait_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      wait_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      occ      <= occ_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        pc1_mem[i]  <= '0;
        dist_mem[i] <= 1'b0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= bus.inst;
      pc_mem[wr_ptr]   <= bus.pc;
      pc1_mem[wr_ptr]  <= bus.pc1;
      dist_mem[wr_ptr] <= bus.distinct;
    end
  end

  logic [31:0]               head_inst;
  logic [INST_MEM_WIDTH-1:0] head_pc;
  logic [INST_MEM_WIDTH-1:0] head_pc1;
  logic                      head_dist;

  // Head view is zeroed whenever nothing is being presented.
  always_comb begin
    head_inst = '0;
    head_pc   = '0;
    head_pc1  = '0;
    head_dist = 1'b0;
    if (out_valid_w) begin
      head_inst = inst_mem[rd_ptr];
      head_pc   = pc_mem[rd_ptr];
      head_pc1  = pc1_mem[rd_ptr];
      head_dist = dist_mem[rd_ptr];
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.out_valid     = out_valid_w;
  assign bus.occupancy     = occ;
  assign bus.opcode        = head_inst[31:26];
  assign bus.rs            = head_inst[25:21];
  assign bus.rt            = head_inst[20:16];
  assign bus.rd            = head_inst[15:11];
  assign bus.sa            = head_inst[10:6];
  assign bus.funct         = head_inst[5:0];
  assign bus.immediate     = head_inst[15:0];
  assign bus.imm_sext      = {{16{head_inst[15]}}, head_inst[15:0]};
  assign bus.inst_index    = head_inst[25:0];
  assign bus.pc_next       = head_pc;
  assign bus.pc1_next      = head_pc1;
  assign bus.distinct_next = head_dist;

  a_occ_bound: assert property (@(posedge CLK) disable iff (!reset) occ <= OCC_FULL);
  a_hold_stall: assert property (@(posedge CLK) disable iff (!reset)
    (out_valid_w && !bus.out_ready && !flush) |=> out_valid_w);
endmodule

// File: tb/tb_inst_decode_queue.sv
// Scoreboard bench for inst_decode_queue: directed stimulus with a W=2 instance and a W=0 instance.
module tb_inst_decode_queue;
  localparam int unsigned IMW   = 2;
  localparam int unsigned DEPTH = 2;

  logic CLK = 1'b0;
  logic reset;
  logic flush;
  logic flush0;

  inst_decode_queue_if #(.INST_MEM_WIDTH(IMW), .DEPTH(DEPTH)) bus ();
  inst_decode_queue_if #(.INST_MEM_WIDTH(IMW), .DEPTH(DEPTH)) bus0 ();

  inst_decode_queue #(.INST_MEM_WIDTH(IMW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .CLK(CLK), .reset(reset), .flush(flush), .bus(bus));
  inst_decode_queue #(.INST_MEM_WIDTH(IMW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .reset(reset), .flush(flush0), .bus(bus0));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] fields;
    logic [31:0] sext;
    logic [25:0] idx;
    logic [15:0] imm;
    logic [4:0]  tags;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode by shifting and masking.
  function automatic exp_t model(input logic [31:0] i, input logic [1:0] p, input logic [1:0] p1,
                                 input logic d);
    exp_t e;
    e.fields = {6'((i >> 26) & 32'h3f), 5'((i >> 21) & 32'h1f), 5'((i >> 16) & 32'h1f),
                5'((i >> 11) & 32'h1f), 5'((i >> 6) & 32'h1f), 6'(i & 32'h3f)};
    e.imm    = 16'(i & 32'hffff);
    e.sext   = (i & 32'h8000) != 0 ? (32'hffff0000 | 32'(e.imm)) : 32'(e.imm);
    e.idx    = 26'(i & 32'h03ff_ffff);
    e.tags   = {p, p1, d};
    return e;
  endfunction

  // Monitor: pop-compare on every consumed head, then record any accepted push.
  always @(negedge CLK) begin
    exp_t e;
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.sa, bus.funct}, e.fields);
          check("mon_imm_sext", bus.imm_sext, e.sext);
          check("mon_inst_index", 32'(bus.inst_index), 32'(e.idx));
          check("mon_immediate", 32'(bus.immediate), 32'(e.imm));
          check("mon_tags", 32'({bus.pc_next, bus.pc1_next, bus.distinct_next}), 32'(e.tags));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.inst, bus.pc, bus.pc1, bus.distinct));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [1:0] p, input logic [1:0] p1,
                       input logic d);
    bus.in_valid = 1'b1;
    bus.inst     = i;
    bus.pc       = p;
    bus.pc1      = p1;
    bus.distinct = d;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.inst     = '0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (bus.occupancy != '0 && n < 40) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(bus.occupancy), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] kk;
    reset = 1'b0;
    flush = 1'b0;
    flush0 = 1'b0;
    bus.out_ready  = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.inst      = '0;
    bus0.pc        = '0;
    bus0.pc1       = '0;
    bus0.distinct  = 1'b0;
    offer(32'h012A4020, 2'd1, 2'd2, 1'b1);
    repeat (3) tick();

    // Reset held with a live offer
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.sa, bus.funct}, 32'd0);
    check("rst_imm_sext", bus.imm_sext, 32'd0);
    check("rst_tags", 32'({bus.pc_next, bus.pc1_next, bus.distinct_next}), 32'd0);
    idle();
    reset = 1'b1;
    tick();

    // add $8,$9,$10 with W=2
    bus.out_ready = 1'b1;
    offer(32'h012A4020, 2'd1, 2'd2, 1'b1);
    tick();
    idle();
    check("t2_occ_waiting", 32'(bus.occupancy), 32'd1);
    check("t2_valid_early", 32'(bus.out_valid), 32'd0);
    check("t2_fields_gated", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.sa, bus.funct}, 32'd0);
    check("t2_pc_gated", 32'(bus.pc_next), 32'd0);
    wait_valid("t2", n);
    check("t2_latency", 32'(n), 32'd2);
    check("t2_rs", 32'(bus.rs), 32'd9);
    check("t2_rt", 32'(bus.rt), 32'd10);
    check("t2_rd", 32'(bus.rd), 32'd8);
    check("t2_funct", 32'(bus.funct), 32'h20);
    check("t2_tags", 32'({bus.pc_next, bus.pc1_next, bus.distinct_next}), 32'b01_10_1);
    tick();
    check("t2_occ_after_pop", 32'(bus.occupancy), 32'd0);
    check("t2_valid_after_pop", 32'(bus.out_valid), 32'd0);

    // Immediate sign extension, both polarities
    offer(32'h21288004, 2'd2, 2'd3, 1'b0);
    tick();
    idle();
    wait_valid("t3a", n);
    check("t3_sext_neg", bus.imm_sext, 32'hFFFF8004);
    check("t3_immediate", 32'(bus.immediate), 32'h8004);
    check("t3_inst_index", 32'(bus.inst_index), 32'h01288004);
    check("t3_opcode", 32'(bus.opcode), 32'd8);
    tick();
    offer(32'h21287FFF, 2'd3, 2'd0, 1'b1);
    tick();
    idle();
    wait_valid("t3b", n);
    check("t3_sext_pos", bus.imm_sext, 32'h00007FFF);
    check("t3_inst_index_b", 32'(bus.inst_index), 32'h01287FFF);
    tick();

    // Fill to DEPTH with execute stalled; third offer must be refused
    bus.out_ready = 1'b0;
    offer(32'h8D090004, 2'd0, 2'd1, 1'b0);
    tick();
    offer(32'hAD0A0008, 2'd3, 2'd2, 1'b1);
    tick();
    check("t4_occ_full", 32'(bus.occupancy), 32'd2);
    check("t4_in_ready_full", 32'(bus.in_ready), 32'd0);
    offer(32'h3C0B1234, 2'd1, 2'd1, 1'b1);
    repeat (4) tick();
    check("t4_occ_held", 32'(bus.occupancy), 32'd2);
    check("t4_head_valid", 32'(bus.out_valid), 32'd1);
    check("t4_head_rs_rt", 32'({bus.rs, bus.rt}), 32'({5'd8, 5'd9}));
    check("t4_head_tags", 32'({bus.pc_next, bus.pc1_next, bus.distinct_next}), 32'b00_01_0);
    idle();
    bus.out_ready = 1'b1;
    wait_empty("t4");

    // Push and pop on the same edge at occupancy 1, eight entries
    offer(32'h20080000, 2'd0, 2'd3, 1'b0);
    tick();
    idle();
    for (int k = 1; k < 8; k++) begin
      kk = 2'(k);
      wait_valid("t5", n);
      offer(32'h20080000 | 32'(k), kk, ~kk, kk[0]);
      tick();
      idle();
      check("t5_occ_steady", 32'(bus.occupancy), 32'd1);
    end
    wait_valid("t5_last", n);
    tick();
    check("t5_occ_end", 32'(bus.occupancy), 32'd0);

    // Flush with a full queue, valid head and a live offer
    bus.out_ready = 1'b0;
    offer(32'h8D090004, 2'd0, 2'd1, 1'b0);
    tick();
    offer(32'hAD0A0008, 2'd3, 2'd2, 1'b1);
    tick();
    idle();
    wait_valid("t6", n);
    check("t6_occ_pre", 32'(bus.occupancy), 32'd2);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    offer(32'h24420001, 2'd2, 2'd2, 1'b1);
    #1;
    check("t6_in_ready_flush", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    idle();
    check("t6_occ_post", 32'(bus.occupancy), 32'd0);
    check("t6_valid_post", 32'(bus.out_valid), 32'd0);
    check("t6_rs_post", 32'(bus.rs), 32'd0);
    repeat (4) tick();
    check("t6_not_stored", 32'({bus.occupancy, bus.out_valid}), 32'd0);

    // Asynchronous reset mid-operation
    offer(32'h012A4020, 2'd1, 2'd1, 1'b1);
    tick();
    idle();
    check("rst2_occ_before", 32'(bus.occupancy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst2_occ_async", 32'(bus.occupancy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rst2_occ_after", 32'(bus.occupancy), 32'd0);

    // WAIT_CYCLES=0 instance: head visible the cycle after push, flush empties it
    bus0.in_valid = 1'b1;
    bus0.inst     = 32'h012A4020;
    bus0.pc       = 2'd1;
    tick();
    bus0.in_valid = 1'b0;
    check("w0_valid_next", 32'(bus0.out_valid), 32'd1);
    check("w0_rd", 32'(bus0.rd), 32'd8);
    check("w0_pc_next", 32'(bus0.pc_next), 32'd1);
    bus0.in_valid = 1'b1;
    bus0.inst     = 32'h21288004;
    tick();
    check("w0_occ_two", 32'(bus0.occupancy), 32'd2);
    check("w0_head_kept", 32'(bus0.rd), 32'd8);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    bus0.in_valid = 1'b0;
    check("w0_flush_occ", 32'(bus0.occupancy), 32'd0);
    check("w0_flush_valid", 32'(bus0.out_valid), 32'd0);
    tick();
    check("w0_flush_hold", 32'(bus0.occupancy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
